trig_record_readout: RTL and testbench

Buffers trigger records and serializes them for readout over a valid/ready word stream. Each record is the 8-bit fired-trigger bitstring plus the 56-bit clock count of the first trigger to fire. The block sits between the trigger decision logic (writer) and the host command/readout path (reader), all in the `clk_adc` domain. It replaces fixed per-slot record registers with an ordered, flushable queue that has overflow reporting.

---
 rtl/trig_record_readout.sv | 155 +++++++++++++++
 tb/tb_trig_record_readout.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/trig_record_readout.sv
// trig_record_readout: queues trigger records ({mask, first-fire clock count})
// in a circular buffer and serializes each one as four 16-bit words on a
// valid/ready stream.
//   clk_adc, rst (async, active-high)
//   rec_wr/rec_mask/rec_time  : record write pulse and payload
//   flush                     : synchronous clear of queue, readout and overflow
//   rd_data/rd_valid/rd_ready : word stream, rd_last marks word 3 of a record
//   fifo_count/empty/full     : records queued, excluding the one being sent
//   overflow                  : sticky, a record was dropped
//   ovf_count                 : dropped-record count, only with TRIG_RECORD_OVF_COUNT_EN
module trig_record_readout #(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned TS_W   = 56,
  parameter int unsigned MASK_W = 8
) (
  input  logic                         clk_adc,
  input  logic                         rst,
  input  logic                         rec_wr,
  input  logic [MASK_W-1:0]            rec_mask,
  input  logic [TS_W-1:0]              rec_time,
  input  logic                         flush,
  output logic [15:0]                  rd_data,
  output logic                         rd_valid,
  input  logic                         rd_ready,
  output logic                         rd_last,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_count,
  output logic                         fifo_empty,
  output logic                         fifo_full,
  output logic                         overflow
`ifdef TRIG_RECORD_OVF_COUNT_EN
  ,
  output logic [15:0]                  ovf_count
`endif
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned CW    = $clog2(DEPTH+1);
  localparam int unsigned REC_W = MASK_W + TS_W;

  typedef enum logic [0:0] {IDLE, SEND} state_t;

  state_t             state_q, state_d;
  logic [REC_W-1:0]   mem [DEPTH];
  logic [AW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [REC_W-1:0]   sreg_q;
  logic [1:0]         idx_q;
  logic               pop, hs, wr_acc, drop;
  logic [CW-1:0]      count_d;

  // Reader FSM next state, pop / handshake decode; flush overrides everything
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    hs      = 1'b0;
    case (state_q)
      IDLE: begin
        if (fifo_count != '0) begin
          pop     = 1'b1;
          state_d = SEND;
        end
      end
      SEND: begin
        if (rd_ready) begin
          hs = 1'b1;
          if (idx_q == 2'd3) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (flush) begin
      state_d = IDLE;
      pop     = 1'b0;
      hs      = 1'b0;
    end
  end

  // A pop in the same cycle frees the slot, so a write at full is still accepted
  always_comb begin
    wr_acc  = rec_wr && !flush && ((fifo_count != CW'(DEPTH)) || pop);
    drop    = rec_wr && !flush && (fifo_count == CW'(DEPTH)) && !pop;
    count_d = fifo_count;
    if (wr_acc && !pop)      count_d = fifo_count + CW'(1);
    else if (pop && !wr_acc) count_d = fifo_count - CW'(1);
  end

  // State register
  always_ff @(posedge clk_adc or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Record storage; at full the popped slot is read before being overwritten
  always_ff @(posedge clk_adc) begin
    if (wr_acc) mem[wr_ptr_q] <= {rec_mask, rec_time};
  end

  // Pointers, count/flags, overflow and word serializer
  always_ff @(posedge clk_adc or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_count <= '0;
      fifo_empty <= 1'b1;
      fifo_full  <= 1'b0;
      overflow   <= 1'b0;
      sreg_q     <= '0;
      idx_q      <= '0;
      rd_valid   <= 1'b0;
      rd_last    <= 1'b0;
      rd_data    <= '0;
    end else if (flush) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_count <= '0;
      fifo_empty <= 1'b1;
      fifo_full  <= 1'b0;
      overflow   <= 1'b0;
      sreg_q     <= '0;
      idx_q      <= '0;
      rd_valid   <= 1'b0;
      rd_last    <= 1'b0;
      rd_data    <= '0;
    end else begin
      if (wr_acc) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)    rd_ptr_q <= rd_ptr_q + AW'(1);
      fifo_count <= count_d;
      fifo_empty <= (count_d == '0);
      fifo_full  <= (count_d == CW'(DEPTH));
      if (drop) overflow <= 1'b1;
      rd_valid <= (state_d == SEND);
      if (pop) begin
        // w0 goes straight out; the remaining three words stay in the shifter
        rd_data <= mem[rd_ptr_q][REC_W-1 -: 16];
        sreg_q  <= mem[rd_ptr_q] << 16;
        idx_q   <= 2'd0;
        rd_last <= 1'b0;
      end else if (hs) begin
        rd_data <= sreg_q[REC_W-1 -: 16];
        sreg_q  <= sreg_q << 16;
        idx_q   <= idx_q + 2'd1;
        rd_last <= (idx_q == 2'd2);
      end
    end
  end

`ifdef TRIG_RECORD_OVF_COUNT_EN
  // Saturating dropped-record counter
  always_ff @(posedge clk_adc or posedge rst) begin
    if (rst)                                  ovf_count <= '0;
    else if (flush)                           ovf_count <= '0;
    else if (drop && (ovf_count != 16'hFFFF)) ovf_count <= ovf_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_trig_record_readout.sv
// Bench for trig_record_readout: directed scenarios with literal expectations
// followed by randomized traffic, all compared against a queue-based model.
module tb_trig_record_readout;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned CW    = $clog2(DEPTH+1);

  logic          clk_adc = 1'b0;
  logic          rst = 1'b1;
  logic          rec_wr = 1'b0;
  logic [7:0]    rec_mask = '0;
  logic [55:0]   rec_time = '0;
  logic          flush = 1'b0;
  logic [15:0]   rd_data;
  logic          rd_valid;
  logic          rd_ready = 1'b0;
  logic          rd_last;
  logic [CW-1:0] fifo_count;
  logic          fifo_empty;
  logic          fifo_full;
  logic          overflow;
`ifdef TRIG_RECORD_OVF_COUNT_EN
  logic [15:0]   ovf_count;
`endif

  trig_record_readout #(.DEPTH(DEPTH), .TS_W(56), .MASK_W(8)) dut (
    .clk_adc   (clk_adc),
    .rst       (rst),
    .rec_wr    (rec_wr),
    .rec_mask  (rec_mask),
    .rec_time  (rec_time),
    .flush     (flush),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .rd_ready  (rd_ready),
    .rd_last   (rd_last),
    .fifo_count(fifo_count),
    .fifo_empty(fifo_empty),
    .fifo_full (fifo_full),
    .overflow  (overflow)
`ifdef TRIG_RECORD_OVF_COUNT_EN
    ,
    .ovf_count (ovf_count)
`endif
  );

  always #5 clk_adc = ~clk_adc;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Model: a record queue plus the record currently on the wire
  logic [63:0] mq[$];
  bit          m_active = 1'b0;
  logic [63:0] m_cur = '0;
  int          m_idx = 0;
  bit          m_ovf = 1'b0;
  int          m_ovfc = 0;

  always @(posedge clk_adc or posedge rst) begin
    if (rst || flush) begin
      mq.delete();
      m_active = 1'b0;
      m_idx    = 0;
      m_ovf    = 1'b0;
      m_ovfc   = 0;
    end else begin
      if (m_active) begin
        if (rd_ready) begin
          m_idx++;
          if (m_idx == 4) m_active = 1'b0;
        end
      end else if (mq.size() > 0) begin
        m_cur    = mq.pop_front();
        m_active = 1'b1;
        m_idx    = 0;
      end
      // Pop already happened above, so a same-cycle pop makes room here
      if (rec_wr) begin
        if (mq.size() < DEPTH) mq.push_back({rec_mask, rec_time});
        else begin
          m_ovf = 1'b1;
          if (m_ovfc < 65535) m_ovfc++;
        end
      end
    end
  end

  // Per-cycle comparison against the model
  bit chk_en = 1'b0;
  always @(negedge clk_adc) begin
    if (chk_en) begin
      logic [63:0] sh;
      chk("m_valid", 64'(rd_valid), 64'(m_active));
      if (m_active) begin
        sh = m_cur << (16 * m_idx);
        chk("m_data", 64'(rd_data), 64'(sh[63:48]));
      end
      chk("m_last", 64'(rd_last), 64'(m_active && m_idx == 3));
      chk("m_count", 64'(fifo_count), 64'(mq.size()));
      chk("m_empty", 64'(fifo_empty), 64'(mq.size() == 0));
      chk("m_full", 64'(fifo_full), 64'(mq.size() == DEPTH));
      chk("m_ovf", 64'(overflow), 64'(m_ovf));
`ifdef TRIG_RECORD_OVF_COUNT_EN
      chk("m_ovfc", 64'(ovf_count), 64'(m_ovfc));
`endif
    end
  end

  task automatic step();
    @(posedge clk_adc);
    #1;
  endtask

  logic [63:0] asm_w = '0;
  logic [55:0] rx_q[$];

  // Capture the currently shown word; it is accepted at the next edge
  task automatic cap();
    if (rd_valid && rd_ready) begin
      asm_w = {asm_w[47:0], rd_data};
      if (rd_last) rx_q.push_back(asm_w[55:0]);
    end
  endtask

  initial begin
    logic [55:0] exp_t[$];
    repeat (3) @(posedge clk_adc);
    #1;
    chk("rst_valid", 64'(rd_valid), 64'd0);
    chk("rst_data", 64'(rd_data), 64'd0);
    chk("rst_count", 64'(fifo_count), 64'd0);
    chk("rst_empty", 64'(fifo_empty), 64'd1);
    chk("rst_full", 64'(fifo_full), 64'd0);
    chk("rst_ovf", 64'(overflow), 64'd0);
    @(negedge clk_adc);
    rst = 1'b0;
    chk_en = 1'b1;
    step();

    // Single record, reader always ready
    rec_wr = 1'b1; rec_mask = 8'h05; rec_time = 56'h00_1234_5678_9ABC; rd_ready = 1'b1;
    step();
    rec_wr = 1'b0;
    chk("t1_count", 64'(fifo_count), 64'd1);
    chk("t1_nvalid", 64'(rd_valid), 64'd0);
    step();
    chk("t1_v", 64'(rd_valid), 64'd1);
    chk("t1_w0", 64'(rd_data), 64'h0500);
    chk("t1_l0", 64'(rd_last), 64'd0);
    chk("t1_cnt0", 64'(fifo_count), 64'd0);
    step(); chk("t1_w1", 64'(rd_data), 64'h1234); chk("t1_l1", 64'(rd_last), 64'd0);
    step(); chk("t1_w2", 64'(rd_data), 64'h5678); chk("t1_l2", 64'(rd_last), 64'd0);
    step(); chk("t1_w3", 64'(rd_data), 64'h9ABC); chk("t1_l3", 64'(rd_last), 64'd1);
    step(); chk("t1_done", 64'(rd_valid), 64'd0);

    // Backpressure: five stalled cycles on w0
    rd_ready = 1'b0; rec_wr = 1'b1;
    step();
    rec_wr = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t2_hold", 64'(rd_data), 64'h0500);
      chk("t2_hv", 64'(rd_valid), 64'd1);
      chk("t2_cnt", 64'(fifo_count), 64'd0);
    end
    rd_ready = 1'b1;
    step(); chk("t2_w1", 64'(rd_data), 64'h1234);
    step(); chk("t2_w2", 64'(rd_data), 64'h5678);
    step(); chk("t2_w3", 64'(rd_data), 64'h9ABC); chk("t2_l3", 64'(rd_last), 64'd1);
    step(); chk("t2_done", 64'(rd_valid), 64'd0);

    // Fill to full and overflow with reader stalled
    rd_ready = 1'b0; rec_mask = 8'hA0;
    for (int k = 1; k <= 10; k++) begin
      rec_wr = 1'b1; rec_time = 56'(k);
      step();
      if (k == 8) begin
        chk("t3_cnt7", 64'(fifo_count), 64'd7);
        chk("t3_nfull", 64'(fifo_full), 64'd0);
      end
      if (k == 9) begin
        chk("t3_cnt8", 64'(fifo_count), 64'd8);
        chk("t3_full", 64'(fifo_full), 64'd1);
        chk("t3_novf", 64'(overflow), 64'd0);
      end
    end
    rec_wr = 1'b0;
    chk("t3_ovf", 64'(overflow), 64'd1);
`ifdef TRIG_RECORD_OVF_COUNT_EN
    chk("t3_ovfc", 64'(ovf_count), 64'd1);
`endif

    // Finish record 1, then write into the pop cycle while full
    rx_q.delete();
    rd_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin cap(); step(); end
    chk("t4_idle", 64'(rd_valid), 64'd0);
    chk("t4_cnt_pre", 64'(fifo_count), 64'd8);
    rec_wr = 1'b1; rec_time = 56'd11;
    step();
    rec_wr = 1'b0;
    chk("t4_cnt", 64'(fifo_count), 64'd8);
    chk("t4_full", 64'(fifo_full), 64'd1);
    for (int i = 0; i < 60; i++) begin cap(); step(); end
    exp_t = '{56'd1, 56'd2, 56'd3, 56'd4, 56'd5, 56'd6, 56'd7, 56'd8, 56'd9, 56'd11};
    chk("t4_nrec", 64'(rx_q.size()), 64'(exp_t.size()));
    for (int i = 0; i < exp_t.size() && i < rx_q.size(); i++)
      chk("t4_order", 64'(rx_q[i]), 64'(exp_t[i]));

    // Flush after w1 is accepted, with a concurrent write
    rec_wr = 1'b1; rec_mask = 8'h3C; rec_time = 56'h00_00AB_CDEF_0123;
    step();
    rec_wr = 1'b0;
    step(); step(); step();
    chk("t5_w2", 64'(rd_data), 64'hCDEF);
    flush = 1'b1; rec_wr = 1'b1;
    step();
    flush = 1'b0; rec_wr = 1'b0;
    chk("t5_valid", 64'(rd_valid), 64'd0);
    chk("t5_cnt", 64'(fifo_count), 64'd0);
    chk("t5_ovf", 64'(overflow), 64'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t5_quiet", 64'(rd_valid), 64'd0);
      chk("t5_empty", 64'(fifo_empty), 64'd1);
    end

    // Asynchronous reset in the middle of a record
    rd_ready = 1'b0; rec_wr = 1'b1; rec_time = 56'h77;
    step();
    rec_wr = 1'b0;
    step();
    chk("t6_sending", 64'(rd_valid), 64'd1);
    #3 rst = 1'b1;
    #1;
    chk("t6_valid", 64'(rd_valid), 64'd0);
    chk("t6_data", 64'(rd_data), 64'd0);
    chk("t6_last", 64'(rd_last), 64'd0);
    chk("t6_empty", 64'(fifo_empty), 64'd1);
    @(negedge clk_adc);
    @(negedge clk_adc);
    rst = 1'b0;
    rd_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t6_noread", 64'(rd_valid), 64'd0);
    end

    // Randomized traffic, alternating reader-fast and reader-slow phases
    for (int c = 0; c < 4000; c++) begin
      int rdy_pct;
      rdy_pct  = ((c / 400) % 2 == 0) ? 90 : 20;
      rec_wr   = ($urandom_range(0, 99) < 45);
      rec_mask = 8'($urandom());
      rec_time = 56'({$urandom(), $urandom()});
      rd_ready = ($urandom_range(0, 99) < rdy_pct);
      flush    = ($urandom_range(0, 299) == 0);
      step();
    end
    rec_wr = 1'b0; flush = 1'b0;
    step();

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
